// File: rtl/serial_cmp_seq.sv
// rtl/serial_cmp_seq.sv - MSB-first serial magnitude compare sequencer driving a shared 1-bit comparator cell
// Optional fixed-latency build: define SERIAL_CMP_FIXED_LAT_EN.
module serial_cmp_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, a_nx, b_nx;
    logic [IDX_W-1:0] idx, idx_nx, idx_dec;
    logic             gt_nx, eq_nx, lt_nx, err_nx;
    logic             cmp_a_nx, cmp_b_nx;
    logic             onehot;

    assign onehot  = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                     ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                     ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);
    assign idx_dec = idx - IDX_W'(1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        a_nx     = a_reg;
        b_nx     = b_reg;
        idx_nx   = idx;
        gt_nx    = gt;
        eq_nx    = eq;
        lt_nx    = lt;
        err_nx   = err;
        cmp_a_nx = cmp_a;
        cmp_b_nx = cmp_b;

        case (state)
            IDLE: begin
                cmp_a_nx = 1'b0;
                cmp_b_nx = 1'b0;
                if (start) begin
                    a_nx     = a_in;
                    b_nx     = b_in;
                    idx_nx   = IDX_W'(WIDTH - 1);
                    gt_nx    = 1'b0;
                    eq_nx    = 1'b0;
                    lt_nx    = 1'b0;
                    err_nx   = 1'b0;
                    // Bit pair is registered so the cell sees clean inputs from the first RUN cycle.
                    cmp_a_nx = a_in[WIDTH-1];
                    cmp_b_nx = b_in[WIDTH-1];
                    state_nx = RUN;
                end
            end

            RUN: begin
                if (!onehot) begin
                    err_nx   = 1'b1;
                    gt_nx    = 1'b0;
                    eq_nx    = 1'b0;
                    lt_nx    = 1'b0;
                    cmp_a_nx = 1'b0;
                    cmp_b_nx = 1'b0;
                    state_nx = DONE;
                end
`ifdef SERIAL_CMP_FIXED_LAT_EN
                else begin
                    // First decisive bit wins; later bits are still walked for constant timing.
                    if (!(gt || lt)) begin
                        gt_nx = cmp_gt;
                        lt_nx = cmp_lt;
                    end
                    if (idx == '0) begin
                        eq_nx    = !(gt || lt) && cmp_eq;
                        cmp_a_nx = 1'b0;
                        cmp_b_nx = 1'b0;
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx_dec;
                        cmp_a_nx = a_reg[idx_dec];
                        cmp_b_nx = b_reg[idx_dec];
                    end
                end
`else
                else if (cmp_gt || cmp_lt) begin
                    gt_nx    = cmp_gt;
                    lt_nx    = cmp_lt;
                    cmp_a_nx = 1'b0;
                    cmp_b_nx = 1'b0;
                    state_nx = DONE;
                end else if (idx == '0) begin
                    eq_nx    = 1'b1;
                    cmp_a_nx = 1'b0;
                    cmp_b_nx = 1'b0;
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx_dec;
                    cmp_a_nx = a_reg[idx_dec];
                    cmp_b_nx = b_reg[idx_dec];
                end
`endif
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
            cmp_a <= 1'b0;
            cmp_b <= 1'b0;
        end else begin
            state <= state_nx;
            a_reg <= a_nx;
            b_reg <= b_nx;
            idx   <= idx_nx;
            gt    <= gt_nx;
            eq    <= eq_nx;
            lt    <= lt_nx;
            err   <= err_nx;
            cmp_a <= cmp_a_nx;
            cmp_b <= cmp_b_nx;
        end
    end

endmodule

// File: doc/serial_cmp_seq.md
Name: serial_cmp_seq

Overview:
- Sequencer that performs a WIDTH-bit unsigned magnitude compare using one external 1-bit comparator cell (gt/eq/lt outputs).
- Latches both operands and feeds the cell one bit pair per cycle, MSB first.
- Samples the cell's combinational result in the same cycle and resolves the A-vs-B relation.
- Sits between the datapath requester and the shared 1-bit comparator cell.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- a_in  in  WIDTH  operand A; sampled on the accepted start.
- b_in  in  WIDTH  operand B; sampled on the accepted start.
- cmp_a  out  1  bit of A currently presented to the cell.
- cmp_b  out  1  bit of B currently presented to the cell.
- cmp_gt  in  1  cell result, A bit > B bit.
- cmp_eq  in  1  cell result, bits equal.
- cmp_lt  in  1  cell result, A bit < B bit.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- gt  out  1  final result A>B.
- eq  out  1  final result A==B.
- lt  out  1  final result A<B.
- err  out  1  cell returned a non-one-hot triple.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE.
  - busy, done, gt, eq, lt, err, cmp_a, cmp_b = 0.
  - Operand registers and index = 0.
  - rst overrides start and any RUN in progress.
  - Any in-progress compare is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmp_a = cmp_b = 0.
  - On start=1: latch a_in/b_in, idx=WIDTH-1, clear gt/eq/lt/err, go to RUN.
- RUN:
  - busy=1.
  - cmp_a = a_reg[idx], cmp_b = b_reg[idx], driven from registers (glitch-free).
  - Each cycle, sample the cmp_gt/eq/lt triple at the clock edge.
  - Triple not exactly one-hot: err=1, gt/eq/lt=0, go to DONE.
  - cmp_gt=1 or cmp_lt=1: record gt/lt, go to DONE (early exit).
  - cmp_eq=1 and idx==0: eq=1, go to DONE.
  - Otherwise idx decrements by 1; no wrap, since idx==0 always exits.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state is IDLE.
- Result hold: gt/eq/lt/err hold their values until the next accepted start.
  - Exactly one of gt/eq/lt is set, unless err=1.
- start handling:
  - start in RUN or DONE is ignored, with no queueing.
  - start held high continuously re-triggers on each IDLE cycle.
- Latency (early exit): first differing bit at position p → WIDTH-p RUN cycles.
  - done is asserted the cycle after the last RUN cycle.
  - Equal operands → WIDTH RUN cycles.
  - Minimum start-to-done latency is 2 cycles; maximum is WIDTH+1.
- a_in/b_in changes after the accepted start have no effect.

Optional Feature:
- Macro: SERIAL_CMP_FIXED_LAT_EN.
- Defined (fixed latency):
  - Early exit is disabled; RUN always lasts WIDTH cycles.
  - The first gt/lt seen is sticky; later bits are still presented but ignored.
  - err still aborts immediately.
  - done is always WIDTH+1 cycles after start, giving constant timing for datapath scheduling.
- Undefined: early-exit behaviour as described in Behaviour.

Test Plan (WIDTH=8; cell model is an ideal 1-bit comparator unless stated):
- Reset then start: a_in=0xA5, b_in=0x25 → differ at bit7; 1 RUN cycle; done 2 cycles after start; gt=1, eq=0, lt=0. With FIXED_LAT: done at +9, gt=1.
- a_in=0x3C, b_in=0x3C → 8 RUN cycles, cmp_a/cmp_b walk bits 7..0; done at +9; eq=1.
- a_in=0x10, b_in=0x11 → lt=1 after 8 RUN cycles; second start pulse during RUN is ignored (single done pulse); results held until next start.
- Cell model forces gt=eq=1 on the 3rd RUN cycle (a_in=b_in=0xFF) → err=1, gt/eq/lt=0, done on the following cycle.
- rst=1 during the 4th RUN cycle of a_in=0x01, b_in=0x00 → next cycle all outputs 0, state IDLE, no done pulse; new start with a_in=0x01, b_in=0x00 → gt=1 at +9.
